// File: rtl/wavetable_voice_bank.sv
// Bank of NUM_CH wavetable phase accumulators sharing one synchronous ROM.
// The ROM is scanned round-robin; each lane gets a volume-scaled sample, and all lanes are summed into mix.
module wavetable_voice_bank #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 13,
  parameter int IDX_W    = 7,
  parameter int SAMPLE_W = 7,
  localparam int MIX_W   = SAMPLE_W + $clog2(NUM_CH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DIV_W-1:0]    divider,
  input  logic [NUM_CH-1:0]          enable,
  input  logic [NUM_CH-1:0]          retrig,
  input  logic [NUM_CH-1:0]          oneshot,
  input  logic [NUM_CH*4-1:0]        volume,
  output logic [IDX_W-1:0]           rom_addr,
  input  logic [SAMPLE_W-1:0]        rom_data,
  output logic [NUM_CH*SAMPLE_W-1:0] sample,
  output logic [NUM_CH-1:0]          active,
  output logic [MIX_W-1:0]           mix
);

  localparam int SCAN_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = SAMPLE_W + 5;

  logic [DIV_W-1:0]    count_q  [NUM_CH];
  logic [DIV_W-1:0]    count_d  [NUM_CH];
  logic [IDX_W-1:0]    idx_q    [NUM_CH];
  logic [IDX_W-1:0]    idx_d    [NUM_CH];
  logic [SAMPLE_W-1:0] sample_q [NUM_CH];
  logic [SAMPLE_W-1:0] sample_d [NUM_CH];
  logic [NUM_CH-1:0]   active_q, active_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [SCAN_W-1:0]   scan_dly_q, scan_dly_d;
  logic [MIX_W-1:0]    mix_q, mix_d;

  logic [3:0]          vol_sel;
  logic [4:0]          vol_p1;
  logic                wr_ok;
  logic [PROD_W-1:0]   prod;
  logic [SAMPLE_W-1:0] scaled;

  // Phase step: retrig beats hold, hold beats countdown, countdown beats reload/step.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      count_d[k]  = count_q[k];
      idx_d[k]    = idx_q[k];
      active_d[k] = active_q[k];
      if (retrig[k]) begin
        idx_d[k]    = '0;
        count_d[k]  = divider[k*DIV_W +: DIV_W];
        active_d[k] = 1'b1;
      end else if (!enable[k] || !active_q[k]) begin
        count_d[k] = count_q[k];
      end else if (count_q[k] != '0) begin
        count_d[k] = count_q[k] - 1'b1;
      end else begin
        count_d[k] = divider[k*DIV_W +: DIV_W];
        if (idx_q[k] != '1) begin
          idx_d[k] = idx_q[k] + 1'b1;
        end else if (!oneshot[k]) begin
          idx_d[k] = '0;
        end else begin
          active_d[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    if (scan_q == SCAN_W'(NUM_CH - 1)) begin
      scan_d = '0;
    end else begin
      scan_d = scan_q + 1'b1;
    end
    scan_dly_d = scan_q;
  end

  always_comb begin
    rom_addr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (scan_q == SCAN_W'(k)) rom_addr = idx_q[k];
    end
  end

  // rom_data belongs to the voice addressed last cycle, i.e. scan_dly_q.
  always_comb begin
    vol_sel = '0;
    wr_ok   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (scan_dly_q == SCAN_W'(k)) begin
        vol_sel = volume[k*4 +: 4];
        wr_ok   = enable[k] & active_q[k];
      end
    end
    vol_p1 = {1'b0, vol_sel} + 5'd1;
    prod   = PROD_W'(rom_data) * PROD_W'(vol_p1);
    scaled = SAMPLE_W'(prod >> 4);
    for (int k = 0; k < NUM_CH; k++) begin
      sample_d[k] = sample_q[k];
      if (scan_dly_q == SCAN_W'(k)) sample_d[k] = wr_ok ? scaled : '0;
    end
  end

  always_comb begin
    mix_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      mix_d = mix_d + MIX_W'(sample_q[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        count_q[k]  <= '0;
        idx_q[k]    <= '0;
        sample_q[k] <= '0;
      end
      active_q   <= '1;
      scan_q     <= '0;
      scan_dly_q <= '0;
      mix_q      <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        count_q[k]  <= count_d[k];
        idx_q[k]    <= idx_d[k];
        sample_q[k] <= sample_d[k];
      end
      active_q   <= active_d;
      scan_q     <= scan_d;
      scan_dly_q <= scan_dly_d;
      mix_q      <= mix_d;
    end
  end

  always_comb begin
    sample = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sample[k*SAMPLE_W +: SAMPLE_W] = sample_q[k];
    end
  end

  assign active = active_q;
  assign mix    = mix_q;

endmodule

// File: tb/tb_wavetable_voice_bank.sv
// Scoreboard bench for wavetable_voice_bank: default 4-voice build with an address-echo ROM,
// plus 6-voice and 1-voice builds fed a full-scale constant ROM.
module tb_wavetable_voice_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4*13-1:0] divider;
  logic [3:0]      enable, retrig, oneshot;
  logic [15:0]     volume;
  logic [6:0]      rom_addr, rom_data;
  logic [27:0]     sample;
  logic [3:0]      active;
  logic [9:0]      mix;

  wavetable_voice_bank u_dut (
    .clk(clk), .rst(rst), .divider(divider), .enable(enable), .retrig(retrig),
    .oneshot(oneshot), .volume(volume), .rom_addr(rom_addr), .rom_data(rom_data),
    .sample(sample), .active(active), .mix(mix)
  );

  // synchronous ROM whose contents equal the address
  always @(posedge clk) rom_data <= rom_addr;

  logic [6*11-1:0] div6;
  logic [5:0]      en6, rt6, os6, act6;
  logic [23:0]     vol6;
  logic [6:0]      addr6;
  logic [7:0]      data6;
  logic [47:0]     smp6;
  logic [10:0]     mix6;

  wavetable_voice_bank #(.NUM_CH(6), .DIV_W(11), .IDX_W(7), .SAMPLE_W(8)) u_dut6 (
    .clk(clk), .rst(rst), .divider(div6), .enable(en6), .retrig(rt6),
    .oneshot(os6), .volume(vol6), .rom_addr(addr6), .rom_data(data6),
    .sample(smp6), .active(act6), .mix(mix6)
  );

  logic [10:0] div1;
  logic [0:0]  en1, rt1, os1, act1;
  logic [3:0]  vol1;
  logic [6:0]  addr1;
  logic [7:0]  data1;
  logic [7:0]  smp1;
  logic [8:0]  mix1;

  wavetable_voice_bank #(.NUM_CH(1), .DIV_W(11), .IDX_W(7), .SAMPLE_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .divider(div1), .enable(en1), .retrig(rt1),
    .oneshot(os1), .volume(vol1), .rom_addr(addr1), .rom_data(data1),
    .sample(smp1), .active(act1), .mix(mix1)
  );

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic exp_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_check(input int obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  function automatic int lane(input int k);
    return int'(sample[k*7 +: 7]);
  endfunction

  task automatic set_div(input int k, input int v);
    divider[k*13 +: 13] = 13'(v);
  endtask

  // Park voice k at index n (n>=1): step every clock, then reload with a huge divider on the n-th step.
  task automatic set_idx(input int k, input int n);
    set_div(k, 0);
    retrig[k] = 1'b1;
    @(negedge clk);
    retrig[k] = 1'b0;
    repeat (n - 1) @(negedge clk);
    set_div(k, 8191);
    @(negedge clk);
  endtask

  int prev, cur, last_t, wraps, nchg, n;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) set_div(k, 3);
    enable = 4'hf; retrig = 4'h0; oneshot = 4'h0; volume = 16'hffff;
    div6 = '0; en6 = '1; rt6 = '0; os6 = '0; vol6 = '1; data6 = 8'hff;
    div1 = '0; en1 = '1; rt1 = '0; os1 = '0; vol1 = 4'hf; data1 = 8'hff;

    repeat (3) @(negedge clk);
    exp_push("rst_sample", 0);    exp_check(int'(sample));
    exp_push("rst_mix", 0);       exp_check(int'(mix));
    exp_push("rst_active", 15);   exp_check(int'(active));
    rst = 1'b0;

    // voice 0 loop: lane 0 follows idx0, +1 every 4 clocks, wrapping 127 -> 0
    prev = lane(0); last_t = -1; wraps = 0; nchg = 0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      cur = lane(0);
      if (cur != prev) begin
        if (last_t >= 0) begin
          exp_push("step_period", 4);
          exp_check(t - last_t);
        end
        exp_push("step_val", (prev + 1) % 128);
        exp_check(cur);
        if (prev == 127 && cur == 0) wraps++;
        prev = cur; last_t = t; nchg++;
      end
    end
    exp_push("wrap_seen", 1);      exp_check(int'(wraps == 1));
    exp_push("step_count_ok", 1);  exp_check(int'(nchg >= 145 && nchg <= 151));
    exp_push("loop_active", 15);   exp_check(int'(active));

    // volume scaling on voice 2 parked at index 40
    set_idx(2, 40);
    repeat (6) @(negedge clk);
    exp_push("vol15_lane2", 40);   exp_check(lane(2));
    volume[11:8] = 4'd7;
    repeat (6) @(negedge clk);
    exp_push("vol7_lane2", 20);    exp_check(lane(2));
    volume[11:8] = 4'hf;

    // one-shot on voice 1 at divider 0: finishes on the 128th step after retrig
    oneshot[1] = 1'b1;
    set_div(1, 0);
    retrig[1] = 1'b1;
    @(negedge clk);
    retrig[1] = 1'b0;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (!active[1]) break;
    end
    exp_push("oneshot_fall_cyc", 128); exp_check(n);
    repeat (6) @(negedge clk);
    exp_push("oneshot_lane1", 0);  exp_check(lane(1));
    exp_push("oneshot_still_off", 0); exp_check(int'(active[1]));
    oneshot[1] = 1'b0;
    retrig[1] = 1'b1;
    @(negedge clk);
    retrig[1] = 1'b0;
    exp_push("retrig_active", 1);  exp_check(int'(active[1]));
    repeat (8) @(negedge clk);
    exp_push("restart_lane1", 1);  exp_check(int'(lane(1) >= 3 && lane(1) <= 8));

    // retrig colliding with a terminal-count step on voice 0
    set_div(0, 7);
    retrig[0] = 1'b1;
    @(negedge clk);
    retrig[0] = 1'b0;
    repeat (7) @(negedge clk);
    retrig[0] = 1'b1;
    @(negedge clk);
    retrig[0] = 1'b0;
    repeat (6) @(negedge clk);
    exp_push("collide_no_step", 0); exp_check(lane(0));
    repeat (8) @(negedge clk);
    exp_push("collide_next_step", 1); exp_check(lane(0));

    // mix of four parked lanes, then voice 3 disabled
    set_idx(0, 10);
    set_idx(1, 20);
    set_idx(2, 30);
    set_idx(3, 40);
    repeat (8) @(negedge clk);
    exp_push("mix_lane0", 10);  exp_check(lane(0));
    exp_push("mix_lane1", 20);  exp_check(lane(1));
    exp_push("mix_lane2", 30);  exp_check(lane(2));
    exp_push("mix_lane3", 40);  exp_check(lane(3));
    exp_push("mix_sum", 100);   exp_check(int'(mix));
    enable[3] = 1'b0;
    repeat (8) @(negedge clk);
    exp_push("dis_lane3", 0);   exp_check(lane(3));
    exp_push("dis_mix", 60);    exp_check(int'(mix));
    enable[3] = 1'b1;

    // wider builds at full scale
    for (int k = 0; k < 6; k++) begin
      exp_push("ch6_lane", 255);
      exp_check(int'(smp6[k*8 +: 8]));
    end
    exp_push("ch6_mix", 6 * 255);  exp_check(int'(mix6));
    exp_push("ch1_lane", 255);     exp_check(int'(smp1));
    exp_push("ch1_mix", 255);      exp_check(int'(mix1));

    // reset mid-run with divider 5, then restart from index 0
    for (int k = 0; k < 4; k++) set_div(k, 5);
    retrig = 4'hf;
    @(negedge clk);
    retrig = 4'h0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_push("midrst_sample", 0);  exp_check(int'(sample));
    exp_push("midrst_mix", 0);     exp_check(int'(mix));
    exp_push("midrst_active", 15); exp_check(int'(active));
    exp_push("midrst_mix6", 0);    exp_check(int'(mix6));
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    exp_push("post_rst_lane0", 1); exp_check(lane(0));
    repeat (4) @(negedge clk);
    exp_push("post_rst_lane0b", 2); exp_check(lane(0));

    exp_push("sb_drained", 0);     exp_check(sb.size() - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
